// File: rtl/fetch_buffer.sv
// Fetch-to-decode instruction queue holding {pc, instr} pairs with valid/ready on both sides.
// Define FETCH_BUFFER_BYPASS_EN to let an entry go straight from input to output when the queue is empty.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_pc,
    input  logic [WIDTH-1:0]         in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_pc,
    output logic [WIDTH-1:0]         out_instr,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] pc_mem    [DEPTH];
    logic [WIDTH-1:0] instr_mem [DEPTH];

    logic stored_valid;
    logic full;
    logic bypass_valid;
    logic bypass_take;
    logic push;
    logic pop;

    assign stored_valid = (count_reg != '0);
    assign full         = (count_reg == CW'(DEPTH));

`ifdef FETCH_BUFFER_BYPASS_EN
    // An empty queue hands the incoming entry straight to decode; a flush cancels it.
    assign bypass_valid = ~stored_valid & in_valid & ~flush;
    assign bypass_take  = bypass_valid & out_ready;
`else
    assign bypass_valid = 1'b0;
    assign bypass_take  = 1'b0;
`endif

    assign in_ready  = ~full;
    assign out_valid = stored_valid | bypass_valid;
    assign push      = in_valid & in_ready & ~bypass_take;
    assign pop       = stored_valid & out_ready;
    assign count     = count_reg;

    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (stored_valid) begin
            out_pc    = pc_mem[rd_ptr_reg];
            out_instr = instr_mem[rd_ptr_reg];
        end else if (bypass_valid) begin
            out_pc    = in_pc;
            out_instr = in_instr;
        end
    end

    // Flush and reset both empty the queue; any same-cycle push or pop is dropped.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (reset || flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (push) wr_ptr_next = wr_ptr_reg + AW'(1);
            if (pop)  rd_ptr_next = rd_ptr_reg + AW'(1);
            if (push && !pop)      count_next = count_reg + CW'(1);
            else if (pop && !push) count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            pc_mem[wr_ptr_reg]    <= in_pc;
            instr_mem[wr_ptr_reg] <= in_instr;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue model tracks contents, a negedge monitor compares outputs.
// Expected contents change at each rising edge from the sampled inputs; checks run on the falling edge.
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc = '0;
    logic [WIDTH-1:0] in_instr = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic [2:0]       count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    bit seen_200 = 1'b0;

    logic [2*WIDTH-1:0] exp_q[$];

    fetch_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bypass_now();
`ifdef FETCH_BUFFER_BYPASS_EN
        return (exp_q.size() == 0) && in_valid && !flush;
`else
        return 1'b0;
`endif
    endfunction

    // Reference model of the queue contents.
    always @(posedge clk) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            bit do_pop;
            bit do_push;
            do_pop  = (exp_q.size() != 0) && out_ready;
            do_push = in_valid && (exp_q.size() != DEPTH) && !(bypass_now() && out_ready);
            if (do_pop)  void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({in_pc, in_instr});
        end
    end

    // Monitor: compares the presented head against the model every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            logic             exp_valid;
            logic [WIDTH-1:0] exp_pc;
            logic [WIDTH-1:0] exp_instr;
            exp_valid = (exp_q.size() != 0) || bypass_now();
            exp_pc    = '0;
            exp_instr = '0;
            if (exp_q.size() != 0) begin
                exp_pc    = exp_q[0][2*WIDTH-1:WIDTH];
                exp_instr = exp_q[0][WIDTH-1:0];
            end else if (bypass_now()) begin
                exp_pc    = in_pc;
                exp_instr = in_instr;
            end
            chk("out_valid", 64'(out_valid), 64'(exp_valid));
            chk("out_pc", 64'(out_pc), 64'(exp_pc));
            chk("out_instr", 64'(out_instr), 64'(exp_instr));
            chk("count", 64'(count), 64'(exp_q.size()));
            chk("in_ready", 64'(in_ready), 64'(exp_q.size() != DEPTH));
            chk("count_max", 64'(count <= 3'(DEPTH)), 64'(1));
            if (out_valid && out_ready) begin
                $display("pop pc=%h instr=%h", out_pc, out_instr);
                if (out_pc == 32'h200) seen_200 = 1'b1;
            end
        end
    end

    task automatic drive(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Lets the last driven cycle take effect, idles the inputs, and stops at the next falling edge.
    task automatic settle();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        int exp_stream;
        logic [31:0] pc;
        // Reset sequence
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_out_pc", 64'(out_pc), 64'(0));
        chk("rst_out_instr", 64'(out_instr), 64'(0));

        // Fill and drain
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h10, 32'hA000_0004, 1'b0, 1'b0);
        settle();
        chk("fill_count", 64'(count), 64'(4));
        chk("fill_in_ready", 64'(in_ready), 64'(0));
        chk("fill_head_pc", 64'(out_pc), 64'(0));
        for (int i = 0; i < 5; i++)
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        settle();
        chk("drain_out_valid", 64'(out_valid), 64'(0));

        // Streaming with wrap-around
`ifdef FETCH_BUFFER_BYPASS_EN
        exp_stream = 0;
`else
        exp_stream = 1;
`endif
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 32'h100 + 32'(i * 4), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
            @(negedge clk);
            if (i > 0) chk("stream_count", 64'(count), 64'(exp_stream));
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        settle();
        chk("stream_empty", 64'(out_valid), 64'(0));

        // Flush with concurrent traffic
        for (int i = 0; i < 3; i++)
            drive(1'b1, 32'h180 + 32'(i * 4), 32'hC000_0000 + 32'(i), 1'b0, 1'b0);
        settle();
        chk("preflush_count", 64'(count), 64'(3));
        drive(1'b1, 32'h200, 32'hDEAD_0200, 1'b1, 1'b1);
        settle();
        chk("flush_count", 64'(count), 64'(0));
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));

        // Full plus pop
        for (int i = 0; i < 4; i++)
            drive(1'b1, 32'h280 + 32'(i * 4), 32'hE000_0000 + 32'(i), 1'b0, 1'b0);
        drive(1'b1, 32'h300, 32'hE000_0300, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_count", 64'(count), 64'(4));
        drive(1'b1, 32'h300, 32'hE000_0300, 1'b1, 1'b0);
        @(negedge clk);
        chk("fullpop_count", 64'(count), 64'(3));
        settle();
        chk("push_after_full_count", 64'(count), 64'(3));
        for (int i = 0; i < 4; i++)
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        settle();
        chk("fullpop_drained", 64'(count), 64'(0));

`ifdef FETCH_BUFFER_BYPASS_EN
        // Bypass when empty
        drive(1'b1, 32'h40, 32'hF000_0040, 1'b1, 1'b0);
        @(negedge clk);
        chk("bypass_valid", 64'(out_valid), 64'(1));
        chk("bypass_pc", 64'(out_pc), 64'(32'h40));
        settle();
        chk("bypass_count", 64'(count), 64'(0));
`endif

        // Randomised traffic with occasional flush
        pc = 32'h1000;
        for (int i = 0; i < 200; i++) begin
            drive(1'(($urandom % 2)), pc, $urandom, 1'(($urandom % 2)), ($urandom % 100) < 5);
            pc += 32'h4;
        end

        // Reset in the middle of traffic empties the queue
        drive(1'b1, pc, 32'h1234_5678, 1'b0, 1'b0);
        drive(1'b1, pc + 32'h4, 32'h1234_5679, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("midreset_count", 64'(count), 64'(0));
        chk("midreset_out_valid", 64'(out_valid), 64'(0));

        chk("pc_200_never_out", 64'(seen_200), 64'(0));
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Small instruction queue between the PC register/instruction-memory fetch stage (producer) and the decode stage (consumer) of the RISC-V core.
- Each entry holds one {pc, instr} pair. Uses valid/ready handshakes on both sides.
- Absorbs decode stalls without stopping fetch. A flush on branch or jump redirect discards all queued entries.

Parameters:
- DEPTH, 4: number of entries. Must be a power of 2, ≥2.
- WIDTH, 32: width of both pc and instr fields.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all entries; sampled on the clock edge
- in_valid  in  1  producer offers {in_pc, in_instr}
- in_ready  out  1  buffer can accept an entry
- in_pc  in  WIDTH  PC of the fetched instruction
- in_instr  in  WIDTH  fetched instruction word
- out_valid  out  1  head entry available
- out_ready  in  1  consumer takes the head entry
- out_pc  out  WIDTH  PC of the head entry
- out_instr  out  WIDTH  instruction of the head entry
- count  out  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Clock and reset:
  - Single clock.
  - Reset is synchronous and active-high. While asserted at a rising edge: wr_ptr=0, rd_ptr=0, count=0.
  - Storage array is not reset.
- Reset values of outputs: out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
- Derived signals:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- in_ready = (count != DEPTH). It is purely a function of the registered count; there is no combinational path from out_ready.
- out_valid = (count != 0).
- out_pc/out_instr:
  - Equal mem[rd_ptr] when out_valid=1.
  - Forced to 0 when out_valid=0.
- Push: write mem[wr_ptr] and increment wr_ptr, wrapping modulo DEPTH.
- Pop: increment rd_ptr, wrapping modulo DEPTH.
- Count update:
  - count +1 on push only.
  - count −1 on pop only.
  - Unchanged on simultaneous push and pop.
- Latency: an entry pushed at edge N is visible on the out_* ports after edge N (i.e. during cycle N+1). This is 1-cycle latency; there is no bypass in the base build.
- Full (count=DEPTH):
  - in_ready=0, so in_valid is ignored.
  - A pop in the same cycle does not enable a push that cycle.
- Empty (count=0): out_valid=0, and out_ready is ignored.
  - A push while empty gives out_valid=1 next cycle.
- Simultaneous push and pop with 0<count<DEPTH: both take effect and count is unchanged.
- Flush priority:
  - flush=1 at an edge sets wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the same cycle is discarded.
  - After the edge: out_valid=0, in_ready=1.
- Reset has priority over flush.
- Reset mid-operation behaves identically to a flush: all contents are lost.
- FIFO order is strict; entries never reorder or duplicate.

Optional Feature:
- Macro: FETCH_BUFFER_BYPASS_EN
- Defined:
  - When count=0 and in_valid=1, out_valid=1 combinationally in the same cycle, with out_pc=in_pc and out_instr=in_instr.
  - If out_ready=1 that cycle, the entry is consumed directly: it is not written, and the pointers and count are unchanged.
  - If out_ready=0, the entry is written normally.
  - flush=1 suppresses bypass: out_valid=0 that cycle.
- Not defined: behaviour exactly as in the base description (1-cycle latency, no in→out combinational path).

Test Plan:
- Reset sequence: hold reset=1 for 2 edges, then release → out_valid=0, in_ready=1, count=0, out_pc=0, out_instr=0.
- Fill and drain:
  - With out_ready=0, push pc=0x0,0x4,0x8,0xC, instr=0xA0000000+i → count=4, in_ready=0.
  - A 5th push (pc=0x10) is ignored.
  - Then hold out_ready=1 → outputs 0x0,0x4,0x8,0xC in order, then out_valid=0.
- Streaming with wrap-around:
  - Continuous in_valid=1 and out_ready=1 for 20 cycles, pc incrementing by 4 from 0x100 → count stays 1 after the first push.
  - Output sequence equals the input sequence delayed 1 cycle.
  - Pointers wrap at least 4 times.
- Flush with concurrent traffic:
  - count=3; assert flush=1 with in_valid=1 (pc=0x200) and out_ready=1 in the same cycle → next cycle count=0, out_valid=0, in_ready=1.
  - pc=0x200 is never output.
- Full plus pop:
  - count=4 with in_valid=1 and out_ready=1 → head pops, no push, count=3.
  - Next cycle the push is accepted → count=3.
- Randomised check (in the style of the block's other benches): 200 cycles of $urandom in_valid/out_ready/in_instr with flush 5% of cycles → a scoreboard queue model matches every popped {pc, instr}, and count never exceeds 4.
- Bypass, with FETCH_BUFFER_BYPASS_EN defined only:
  - Empty buffer, in_valid=1, pc=0x40, out_ready=1 → out_valid=1 and out_pc=0x40 in the same cycle.
  - count remains 0 afterwards.
